// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg
//   Shared constants and the hex-to-glyph table for the seven-segment scanner.
//   Segment encodings are active-low; bit 4 is the decimal point.
package seven_segment_pkg;

   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam int         SEG_DP_BIT = 4;
   localparam int         MAX_DIGITS = 8;

   // Active-low glyph for one hex nibble (DP segment left off).
   function automatic logic [7:0] hexToSegments(input logic [3:0] nibble);
      logic [7:0] seg;
      case (nibble)
         4'h0: seg = 8'h11;
         4'h1: seg = 8'hD7;
         4'h2: seg = 8'h32;
         4'h3: seg = 8'h92;
         4'h4: seg = 8'hD4;
         4'h5: seg = 8'h98;
         4'h6: seg = 8'h18;
         4'h7: seg = 8'hD3;
         4'h8: seg = 8'h10;
         4'h9: seg = 8'h90;
         4'hA: seg = 8'h50;
         4'hB: seg = 8'h1C;
         4'hC: seg = 8'h39;
         4'hD: seg = 8'h16;
         4'hE: seg = 8'h38;
         default: seg = 8'h78;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/segment_refresh_timer.sv
// segment_refresh_timer
//   Slot prescaler and digit index for the scanner.
//   Ports:
//     clock, resetN   clock / async active-low reset
//     idx             digit currently owning the slot (0 = rightmost)
//     blank           prescaler is inside the inter-digit dark window
//     frame_boundary  first cycle of digit 0's slot (idx 0, prescaler 0)
module segment_refresh_timer
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic             clock,
   input  logic             resetN,
   output logic [IDX_W-1:0] idx,
   output logic             blank,
   output logic             frame_boundary
);

   localparam int PRE_W = $clog2(REFRESH_DIV);

   logic [PRE_W-1:0] presc;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == PRE_W'(REFRESH_DIV - 1)) begin
         presc <= '0;
         idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   assign blank          = (presc < PRE_W'(BLANK_CYCLES));
   assign frame_boundary = (presc == '0) && (idx == '0);

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   Inputs are captured into a pending buffer on loadData and promoted to the
//   active buffer only at the frame boundary, so a frame never mixes values.
//   Ports:
//     clock, resetN        clock / async active-low reset
//     digitData            hex nibbles, [3:0] = digit 0
//     decimalPoint         per-digit DP enable
//     digitBlank           per-digit force-dark
//     zeroSuppress         blank leading zero digits
//     loadData             capture the four inputs above
//     sevenSegmentEnable   active-low digit anodes
//     sevenSegmentData     active-low segments, bit 4 = DP
//     frameStart           1-cycle pulse as digit 0's slot begins
module seven_segment_scanner
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clock,
   input  logic                    resetN,
   input  logic [4*NUM_DIGITS-1:0] digitData,
   input  logic [NUM_DIGITS-1:0]   decimalPoint,
   input  logic [NUM_DIGITS-1:0]   digitBlank,
   input  logic                    zeroSuppress,
   input  logic                    loadData,
   output logic [NUM_DIGITS-1:0]   sevenSegmentEnable,
   output logic [7:0]              sevenSegmentData,
   output logic                    frameStart
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [IDX_W-1:0] idx;
   logic             blank;
   logic             frame_boundary;

   segment_refresh_timer #(
      .NUM_DIGITS  (NUM_DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .BLANK_CYCLES(BLANK_CYCLES),
      .IDX_W       (IDX_W)
   ) u_timer (
      .clock         (clock),
      .resetN        (resetN),
      .idx           (idx),
      .blank         (blank),
      .frame_boundary(frame_boundary)
   );

   logic [4*NUM_DIGITS-1:0] pend_data,  act_data;
   logic [NUM_DIGITS-1:0]   pend_dp,    act_dp;
   logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
   logic                    pend_zs,    act_zs;

   logic [NUM_DIGITS-1:0]   lz;
   logic                    above;
   logic [3:0]              nibble;
   logic                    dark;
   logic [NUM_DIGITS-1:0]   nxt_en;
   logic [7:0]              nxt_data;

   // Leading-zero chain from the top digit down; a lit DP breaks the chain
   // so that digit and everything below it stay visible. Digit 0 always shows.
   always_comb begin
      lz    = '0;
      above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lz[i] = above && (act_data[4*i +: 4] == 4'h0) && !act_dp[i];
         above = lz[i];
      end
   end

   always_comb begin
      nibble   = act_data[{idx, 2'b00} +: 4];
      dark     = act_blank[idx] | (act_zs & lz[idx]);
      nxt_en   = '1;
      nxt_data = SEG_BLANK;
      if (!blank && !dark) begin
         nxt_en[idx] = 1'b0;
         nxt_data    = hexToSegments(nibble);
         if (act_dp[idx]) nxt_data[SEG_DP_BIT] = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         pend_data          <= '0;
         pend_dp            <= '0;
         pend_blank         <= '0;
         pend_zs            <= 1'b0;
         act_data           <= '0;
         act_dp             <= '0;
         act_blank          <= '0;
         act_zs             <= 1'b0;
         sevenSegmentEnable <= '1;
         sevenSegmentData   <= SEG_BLANK;
         frameStart         <= 1'b0;
      end else begin
         if (loadData) begin
            pend_data  <= digitData;
            pend_dp    <= decimalPoint;
            pend_blank <= digitBlank;
            pend_zs    <= zeroSuppress;
         end
         // Promotion reads pending before this edge's load, so a load on the
         // boundary cycle waits for the following frame.
         if (frame_boundary) begin
            act_data  <= pend_data;
            act_dp    <= pend_dp;
            act_blank <= pend_blank;
            act_zs    <= pend_zs;
         end
         sevenSegmentEnable <= nxt_en;
         sevenSegmentData   <= nxt_data;
         frameStart         <= frame_boundary;
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//   Directed bench for seven_segment_scanner with NUM_DIGITS=4, REFRESH_DIV=8,
//   BLANK_CYCLES=2. cyc counts negedges since reset release; the outputs seen
//   at cyc reflect timer state s = cyc-1, where digit d of frame f spans
//   states 32f+8d .. 32f+8d+7 (first two dark).
module tb_seven_segment_scanner;

   logic        clock = 1'b0;
   logic        resetN;
   logic [15:0] digitData;
   logic [3:0]  decimalPoint;
   logic [3:0]  digitBlank;
   logic        zeroSuppress;
   logic        loadData;
   logic [3:0]  sevenSegmentEnable;
   logic [7:0]  sevenSegmentData;
   logic        frameStart;

   int tests  = 0;
   int fails  = 0;
   int cyc    = 0;

   seven_segment_scanner #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (8),
      .BLANK_CYCLES(2)
   ) dut (
      .clock             (clock),
      .resetN            (resetN),
      .digitData         (digitData),
      .decimalPoint      (decimalPoint),
      .digitBlank        (digitBlank),
      .zeroSuppress      (zeroSuppress),
      .loadData          (loadData),
      .sevenSegmentEnable(sevenSegmentEnable),
      .sevenSegmentData  (sevenSegmentData),
      .frameStart        (frameStart)
   );

   always #5 clock = ~clock;

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic goto_state(input int s);
      while (cyc - 1 < s) step(1);
   endtask

   function automatic int next_frame();
      return (cyc + 31) / 32;
   endfunction

   task automatic load(input logic [15:0] d, input logic [3:0] dp,
                       input logic [3:0] bl, input logic zs);
      digitData    = d;
      decimalPoint = dp;
      digitBlank   = bl;
      zeroSuppress = zs;
      loadData     = 1'b1;
      step(1);
      loadData     = 1'b0;
   endtask

   // Samples the middle of each digit's drive window in frame f.
   task automatic capture_frame(input int f, output logic [15:0] ens,
                                output logic [31:0] dats);
      for (int d = 0; d < 4; d++) begin
         goto_state(32*f + 8*d + 4);
         ens[4*d +: 4]  = sevenSegmentEnable;
         dats[8*d +: 8] = sevenSegmentData;
      end
   endtask

   task automatic test_reset();
      logic [3:0] ee;
      resetN = 1'b0; digitData = '0; decimalPoint = '0; digitBlank = '0;
      zeroSuppress = 1'b0; loadData = 1'b0;
      step(3);
      tests++; if (sevenSegmentEnable !== 4'hF) begin fails++; $display("FAIL reset_en got %h exp f", sevenSegmentEnable); end
      tests++; if (sevenSegmentData !== 8'hFF) begin fails++; $display("FAIL reset_data got %h exp ff", sevenSegmentData); end
      tests++; if (frameStart !== 1'b0) begin fails++; $display("FAIL reset_fs got %b exp 0", frameStart); end
      resetN = 1'b1;
      cyc = 0;
      step(1);
      tests++; if (sevenSegmentEnable !== 4'hF || sevenSegmentData !== 8'hFF) begin fails++; $display("FAIL rel_c1 got %h/%h exp f/ff", sevenSegmentEnable, sevenSegmentData); end
      tests++; if (frameStart !== 1'b1) begin fails++; $display("FAIL rel_fs1 got %b exp 1", frameStart); end
      step(1);
      tests++; if (sevenSegmentEnable !== 4'hF || sevenSegmentData !== 8'hFF) begin fails++; $display("FAIL rel_c2 got %h/%h exp f/ff", sevenSegmentEnable, sevenSegmentData); end
      tests++; if (frameStart !== 1'b0) begin fails++; $display("FAIL rel_fs2 got %b exp 0", frameStart); end
      step(1);
      tests++; if (sevenSegmentEnable !== 4'hE || sevenSegmentData !== 8'h11) begin fails++; $display("FAIL rel_c3 got %h/%h exp e/11", sevenSegmentEnable, sevenSegmentData); end
      for (int k = 1; k <= 3; k++) begin
         ee = 4'hF ^ (4'h1 << k);
         goto_state(8*k + 1);
         tests++; if (sevenSegmentEnable !== 4'hF) begin fails++; $display("FAIL idx_blank%0d got %h exp f", k, sevenSegmentEnable); end
         goto_state(8*k + 4);
         tests++; if (sevenSegmentEnable !== ee || sevenSegmentData !== 8'h11) begin fails++; $display("FAIL idx_drive%0d got %h/%h exp %h/11", k, sevenSegmentEnable, sevenSegmentData, ee); end
      end
      goto_state(31);
      tests++; if (frameStart !== 1'b0) begin fails++; $display("FAIL fs_pre got %b exp 0", frameStart); end
      goto_state(32);
      tests++; if (frameStart !== 1'b1) begin fails++; $display("FAIL fs_frame1 got %b exp 1", frameStart); end
      goto_state(33);
      tests++; if (frameStart !== 1'b0) begin fails++; $display("FAIL fs_post got %b exp 0", frameStart); end
      goto_state(36);
      tests++; if (sevenSegmentEnable !== 4'hE || sevenSegmentData !== 8'h11) begin fails++; $display("FAIL idx_wrap got %h/%h exp e/11", sevenSegmentEnable, sevenSegmentData); end
   endtask

   task automatic test_load_basic();
      logic [15:0] ens; logic [31:0] dats; int f;
      load(16'h12A8, 4'b0001, 4'b0000, 1'b0);
      f = next_frame();
      capture_frame(f, ens, dats);
      tests++; if (ens !== 16'h7BDE) begin fails++; $display("FAIL load_en got %h exp 7bde", ens); end
      tests++; if (dats !== 32'hD7325000) begin fails++; $display("FAIL load_data got %h exp d7325000", dats); end
   endtask

   task automatic test_zero_suppress();
      logic [15:0] ens; logic [31:0] dats; int f;
      load(16'h0050, 4'b0000, 4'b0000, 1'b1);
      f = next_frame();
      capture_frame(f, ens, dats);
      tests++; if (ens !== 16'hFFDE) begin fails++; $display("FAIL zs_en got %h exp ffde", ens); end
      tests++; if (dats !== 32'hFFFF9811) begin fails++; $display("FAIL zs_data got %h exp ffff9811", dats); end
      load(16'h0050, 4'b0100, 4'b0000, 1'b1);
      f = next_frame();
      capture_frame(f, ens, dats);
      tests++; if (ens !== 16'hFBDE) begin fails++; $display("FAIL zs_dp_en got %h exp fbde", ens); end
      tests++; if (dats !== 32'hFF019811) begin fails++; $display("FAIL zs_dp_data got %h exp ff019811", dats); end
   endtask

   task automatic test_mid_frame();
      logic [15:0] ens; logic [31:0] dats; int f;
      load(16'h4321, 4'b0000, 4'b0000, 1'b0);
      f = next_frame();
      capture_frame(f, ens, dats);
      tests++; if (dats !== 32'hD49232D7) begin fails++; $display("FAIL mid_old got %h exp d49232d7", dats); end
      goto_state(32*(f+1) + 17);
      load(16'h8765, 4'b0000, 4'b0000, 1'b0);
      goto_state(32*(f+1) + 20);
      tests++; if (sevenSegmentEnable !== 4'hB || sevenSegmentData !== 8'h92) begin fails++; $display("FAIL mid_d2 got %h/%h exp b/92", sevenSegmentEnable, sevenSegmentData); end
      goto_state(32*(f+1) + 28);
      tests++; if (sevenSegmentEnable !== 4'h7 || sevenSegmentData !== 8'hD4) begin fails++; $display("FAIL mid_d3 got %h/%h exp 7/d4", sevenSegmentEnable, sevenSegmentData); end
      capture_frame(f + 2, ens, dats);
      tests++; if (dats !== 32'h10D31898) begin fails++; $display("FAIL mid_new got %h exp 10d31898", dats); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ens; logic [31:0] dats; int g;
      g = cyc / 32 + 1;
      goto_state(32*g + 5);
      load(16'hBBBB, 4'b0000, 4'b0000, 1'b0);
      load(16'h2222, 4'b0000, 4'b0000, 1'b0);
      capture_frame(g + 1, ens, dats);
      tests++; if (dats !== 32'h32323232) begin fails++; $display("FAIL b2b_last got %h exp 32323232", dats); end
      // load captured on the boundary edge itself
      g = cyc / 32 + 1;
      goto_state(32*g - 1);
      load(16'h1111, 4'b0000, 4'b0000, 1'b0);
      capture_frame(g, ens, dats);
      tests++; if (dats !== 32'h32323232) begin fails++; $display("FAIL bnd_old got %h exp 32323232", dats); end
      capture_frame(g + 1, ens, dats);
      tests++; if (dats !== 32'hD7D7D7D7) begin fails++; $display("FAIL bnd_new got %h exp d7d7d7d7", dats); end
   endtask

   task automatic test_digit_blank();
      logic [15:0] ens; logic [31:0] dats; int f;
      load(16'h8888, 4'b0000, 4'b0100, 1'b0);
      f = next_frame();
      capture_frame(f, ens, dats);
      tests++; if (ens !== 16'h7FDE) begin fails++; $display("FAIL blank_en got %h exp 7fde", ens); end
      tests++; if (dats !== 32'h10FF1010) begin fails++; $display("FAIL blank_data got %h exp 10ff1010", dats); end
      for (int s = 0; s < 8; s++) begin
         goto_state(32*(f+1) + 16 + s);
         tests++; if (sevenSegmentEnable !== 4'hF || sevenSegmentData !== 8'hFF) begin fails++; $display("FAIL blank_slot%0d got %h/%h exp f/ff", s, sevenSegmentEnable, sevenSegmentData); end
      end
   endtask

   task automatic test_reset_mid();
      int g;
      g = cyc / 32 + 1;
      goto_state(32*g + 12);
      tests++; if (sevenSegmentEnable !== 4'hD) begin fails++; $display("FAIL rstmid_pre got %h exp d", sevenSegmentEnable); end
      resetN = 1'b0;
      #1;
      tests++; if (sevenSegmentEnable !== 4'hF || sevenSegmentData !== 8'hFF || frameStart !== 1'b0) begin fails++; $display("FAIL rstmid_async got %h/%h/%b exp f/ff/0", sevenSegmentEnable, sevenSegmentData, frameStart); end
      step(2);
      resetN = 1'b1;
      cyc = 0;
      step(1);
      tests++; if (frameStart !== 1'b1 || sevenSegmentEnable !== 4'hF) begin fails++; $display("FAIL rstmid_rel got %b/%h exp 1/f", frameStart, sevenSegmentEnable); end
      goto_state(2);
      tests++; if (sevenSegmentEnable !== 4'hE || sevenSegmentData !== 8'h11) begin fails++; $display("FAIL rstmid_d0 got %h/%h exp e/11", sevenSegmentEnable, sevenSegmentData); end
      goto_state(12);
      tests++; if (sevenSegmentEnable !== 4'hD || sevenSegmentData !== 8'h11) begin fails++; $display("FAIL rstmid_d1 got %h/%h exp d/11", sevenSegmentEnable, sevenSegmentData); end
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_zero_suppress();
      test_mid_frame();
      test_back_to_back();
      test_digit_blank();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
